// File: rtl/riscv_data_memory.sv
`timescale 1ns/1ps
// riscv_data_memory
// Word-organized data RAM that responds on the core's data port. It takes
// byte/half/word loads and stores, inserts WAIT_STATES stall cycles per
// access, aligns byte lanes both ways and flags misaligned or out-of-range
// accesses. Request fields are not latched. The initiator holds them stable
// until the access completes.
//
// Wait-state sequencer (only built when WAIT_STATES >= 1):
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | no access in flight; ready = !request, a request starts a stall
//   ST_WAIT  | stalling, cnt counts down the remaining low cycles
//   ST_GRANT | ready high; a still-present request completes this cycle
module riscv_data_memory #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        data_read_valid,
   input  logic        data_write_valid,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_write,
   input  logic [3:0]  data_write_byte,
   output logic [31:0] data_read,
   output logic        data_ready,
   output logic        data_error
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic          request;
   logic          is_store;
   logic          is_load;
   logic          complete;
   logic [1:0]    off;
   logic [29:0]   word_idx;
   logic [AW-1:0] mem_idx;

   logic          size_ok;
   logic          align_ok;
   logic          range_ok;
   logic          acc_err;

   logic [3:0]    lane_en;
   logic [31:0]   lane_data;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   rd_mask;

   logic [31:0]   mem [DEPTH_WORDS];

   // A store wins when both strobes are high.
   assign request  = data_read_valid | data_write_valid;
   assign is_store = data_write_valid;
   assign is_load  = data_read_valid & ~data_write_valid;
   assign complete = request & data_ready;

   assign off      = data_addr[1:0];
   assign word_idx = data_addr[31:2];
   assign mem_idx  = word_idx[AW-1:0];

   // The full 30-bit word index is compared, so high address bits never alias.
   assign range_ok = ({2'b00, word_idx} < DEPTH_WORDS);
   assign acc_err  = ~(size_ok & align_ok & range_ok);

   // Decode the size mask into a legality flag, an alignment rule and a load mask.
   always_comb begin
      size_ok  = 1'b1;
      align_ok = 1'b1;
      rd_mask  = 32'h0000_0000;
      case (data_write_byte)
         4'b0001: begin
            rd_mask = 32'h0000_00FF;
         end
         4'b0011: begin
            rd_mask  = 32'h0000_FFFF;
            align_ok = ~off[0];
         end
         4'b1111: begin
            rd_mask  = 32'hFFFF_FFFF;
            align_ok = (off == 2'b00);
         end
         default: begin
            size_ok = 1'b0;
         end
      endcase
   end

   // Move right-justified store data and mask up into the addressed lanes, and
   // bring the addressed lanes of the read word down to bit 0 for loads.
   always_comb begin
      lane_en   = data_write_byte << off;
      lane_data = data_write << {off, 3'b000};
      rd_word   = mem[mem_idx];
      rd_shift  = rd_word >> {off, 3'b000};
   end

   // RAM array: no reset, byte-lane write on a completing, error-free store.
   always_ff @(posedge clk) begin
      if (complete && is_store && !acc_err) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) begin
               mem[mem_idx][8*b +: 8] <= lane_data[8*b +: 8];
            end
         end
      end
   end

   // Registered load result and one-cycle error flag, both one cycle after completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_read  <= 32'h0000_0000;
         data_error <= 1'b0;
      end else begin
         data_error <= complete & acc_err;
         if (complete && is_load) begin
            data_read <= acc_err ? 32'h0000_0000 : (rd_shift & rd_mask);
         end
      end
   end

   generate
      if (WAIT_STATES == 0) begin : g_no_wait
         // Zero wait states: every presented request completes in its first cycle.
         assign data_ready = 1'b1;
      end else begin : g_fsm
         typedef enum logic [1:0] {
            ST_IDLE  = 2'd0,
            ST_WAIT  = 2'd1,
            ST_GRANT = 2'd2
         } state_t;

         // The IDLE cycle counts as the first low cycle, so WAIT covers the
         // remaining WAIT_STATES-1 cycles and cnt starts at WAIT_STATES-2.
         localparam logic [3:0] CNT_INIT =
            4'((WAIT_STATES >= 2) ? (WAIT_STATES - 2) : 0);

         state_t     state;
         state_t     state_nxt;
         logic [3:0] cnt;
         logic [3:0] cnt_nxt;
         logic       ready_fsm;

         // State and wait counter registers; reset drops any access in flight.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               state <= ST_IDLE;
               cnt   <= 4'd0;
            end else begin
               state <= state_nxt;
               cnt   <= cnt_nxt;
            end
         end

         // Next-state and ready decode.
         always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            ready_fsm = 1'b0;
            case (state)
               ST_IDLE: begin
                  ready_fsm = ~request;
                  if (request) begin
                     if (WAIT_STATES == 1) begin
                        state_nxt = ST_GRANT;
                     end else begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = CNT_INIT;
                     end
                  end
               end
               ST_WAIT: begin
                  if (!request) begin
                     state_nxt = ST_IDLE;
                  end else if (cnt == 4'd0) begin
                     state_nxt = ST_GRANT;
                  end else begin
                     cnt_nxt = cnt - 4'd1;
                  end
               end
               ST_GRANT: begin
                  ready_fsm = 1'b1;
                  state_nxt = ST_IDLE;
               end
               default: begin
                  state_nxt = ST_IDLE;
               end
            endcase
         end

         assign data_ready = ready_fsm;
      end
   endgenerate

endmodule

// File: tb/tb_riscv_data_memory.sv
`timescale 1ns/1ps
// Bench for riscv_data_memory: four instances with WAIT_STATES 0..3, a
// byte-array reference model, and a scoreboard monitor that checks every
// response cycle against expectations queued by the stimulus tasks.
module tb_riscv_data_memory;

   localparam int DEPTH = 64;
   localparam int NU    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [NU];
   logic        rv   [NU];
   logic        wv   [NU];
   logic [31:0] addr [NU];
   logic [31:0] wd   [NU];
   logic [3:0]  be   [NU];
   logic [31:0] rdat [NU];
   logic        rdy  [NU];
   logic        err  [NU];

   for (genvar g = 0; g < NU; g++) begin : g_dut
      riscv_data_memory #(
         .DEPTH_WORDS(DEPTH),
         .WAIT_STATES(g)
      ) u_dut (
         .clk              (clk),
         .reset_n          (rst[g]),
         .data_read_valid  (rv[g]),
         .data_write_valid (wv[g]),
         .data_addr        (addr[g]),
         .data_write       (wd[g]),
         .data_write_byte  (be[g]),
         .data_read        (rdat[g]),
         .data_ready       (rdy[g]),
         .data_error       (err[g])
      );
   end

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          u;
      logic [31:0] rd;
      logic        er;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  mb [NU][DEPTH*4];
   logic [31:0] last_read [NU];
   bit          fire [NU];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: memory as a flat byte array, sizes and legality from the mask.
   task automatic model(input int u, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      int              sz;
      bit              e;
      logic [31:0]     v;
      longint unsigned la;
      exp_t            x;
      la = a;
      case (m)
         4'b0001: sz = 1;
         4'b0011: sz = 2;
         4'b1111: sz = 4;
         default: sz = 0;
      endcase
      e = (sz == 0);
      if (!e) e = (la / 4 >= DEPTH) || (la % sz != 0);
      if (wr) begin
         if (!e) for (int i = 0; i < sz; i++) mb[u][int'(la) + i] = d[8*i +: 8];
         x.rd = last_read[u];
      end else begin
         v = 32'h0;
         if (!e) for (int i = 0; i < sz; i++) v = v | (32'(mb[u][int'(la) + i]) << (8*i));
         last_read[u] = v;
         x.rd = v;
      end
      x.u  = u;
      x.er = e;
      q.push_back(x);
   endtask

   // Present one request, count low-ready cycles, and queue the expected response.
   task automatic access(input int u, input bit wr, input bit rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input bit keep);
      int lows;
      @(negedge clk);
      wv[u] = wr; rv[u] = rd; addr[u] = a; wd[u] = d; be[u] = m;
      #1;
      lows = 0;
      while (!rdy[u] && lows < 40) begin
         lows++;
         @(negedge clk);
         #1;
      end
      if (lows >= 40) begin
         total++; bad++;
         $display("FAIL ready_timeout u%0d: ready stayed %b for %0d cycles, required 1", u, rdy[u], lows);
         wv[u] = 1'b0; rv[u] = 1'b0;
         return;
      end
      chk($sformatf("stall_cycles_u%0d", u), lows, u);
      @(posedge clk);
      model(u, wr, a, d, m);
      if (!keep) begin
         @(negedge clk);
         wv[u] = 1'b0; rv[u] = 1'b0;
      end
   endtask

   // Present a request, then drop it before it completes.
   task automatic withdraw(input int u, input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m, input int n);
      @(negedge clk);
      wv[u] = wr; rv[u] = rd; addr[u] = a; wd[u] = d; be[u] = m;
      repeat (n + 1) @(negedge clk);
      wv[u] = 1'b0; rv[u] = 1'b0;
      @(negedge clk);
      #1;
      chk($sformatf("ready_after_withdraw_u%0d", u), rdy[u], 1);
   endtask

   // Assert reset while a store is stalled in WAIT.
   task automatic reset_mid_wait(input int u, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      wv[u] = 1'b1; rv[u] = 1'b0; addr[u] = a; wd[u] = d; be[u] = 4'hF;
      @(negedge clk);
      #3;
      rst[u] = 1'b0;
      last_read[u] = 32'h0;
      #1;
      chk("reset_async_read", rdat[u], 0);
      chk("reset_async_error", err[u], 0);
      wv[u] = 1'b0;
      #1;
      chk("reset_async_ready", rdy[u], 1);
      @(negedge clk);
      rst[u] = 1'b1;
   endtask

   task automatic idle(input int u);
      @(negedge clk);
      wv[u] = 1'b0; rv[u] = 1'b0;
   endtask

   // Scoreboard monitor: detects completions before the edge, checks outputs after it.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         for (int u = 0; u < NU; u++) fire[u] = rst[u] && (rv[u] || wv[u]) && rdy[u];
         if (rst[0]) chk("ws0_ready_high", rdy[0], 1);
         @(posedge clk);
         #1;
         for (int u = 0; u < NU; u++) begin
            if (!rst[u]) continue;
            if (fire[u]) begin
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL no_expectation u%0d: completion seen, none queued", u);
               end else begin
                  x = q.pop_front();
                  chk("resp_unit", u, x.u);
                  chk($sformatf("resp_read_u%0d", u), rdat[u], x.rd);
                  chk($sformatf("resp_error_u%0d", u), err[u], x.er);
               end
            end else begin
               chk($sformatf("idle_error_u%0d", u), err[u], 0);
               chk($sformatf("idle_read_hold_u%0d", u), rdat[u], last_read[u]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int u = 0; u < NU; u++) begin
         rst[u] = 1'b0; rv[u] = 1'b0; wv[u] = 1'b0;
         addr[u] = 32'h0; wd[u] = 32'h0; be[u] = 4'h0;
         last_read[u] = 32'h0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int u = 0; u < NU; u++) begin
         chk("reset_read", rdat[u], 0);
         chk("reset_error", err[u], 0);
         chk("reset_ready", rdy[u], 1);
      end
      @(negedge clk);
      for (int u = 0; u < NU; u++) rst[u] = 1'b1;

      // Fill every word so the model and the RAM agree everywhere.
      for (int u = 0; u < NU; u++)
         for (int w = 0; w < DEPTH; w++)
            access(u, 1, 0, 32'(w * 4), $urandom, 4'hF, w != DEPTH - 1);

      // Zero-wait word store and load.
      access(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 0);
      access(0, 0, 1, 32'h10, 32'h0, 4'hF, 0);
      chk("ws0_word_load", last_read[0], 32'hDEADBEEF);

      // Byte lanes on every wait-state setting.
      for (int u = 0; u < NU; u++) begin
         access(u, 1, 0, 32'h10, 32'h11223344, 4'hF, 0);
         access(u, 1, 0, 32'h13, 32'h000000AA, 4'b0001, 0);
         access(u, 0, 1, 32'h13, 32'h0, 4'b0001, 0);
         access(u, 0, 1, 32'h12, 32'h0, 4'b0011, 0);
         access(u, 0, 1, 32'h10, 32'h0, 4'hF, 0);
      end

      // Back-to-back loads with three wait states.
      access(3, 0, 1, 32'h10, 32'h0, 4'hF, 1);
      access(3, 0, 1, 32'h14, 32'h0, 4'hF, 0);

      // Error cases.
      for (int u = 0; u < NU; u++) begin
         access(u, 1, 0, 32'h21, 32'h0000BEEF, 4'b0011, 0);
         access(u, 0, 1, 32'h20, 32'h0, 4'hF, 0);
         access(u, 0, 1, 32'(DEPTH * 4), 32'h0, 4'hF, 0);
         access(u, 0, 1, 32'h10, 32'h0, 4'b0101, 0);
         access(u, 1, 0, 32'h10, 32'h12345678, 4'b0101, 0);
         access(u, 0, 1, 32'hFFFF_FFFC, 32'h0, 4'hF, 0);
         access(u, 0, 1, 32'h10, 32'h0, 4'hF, 0);
      end

      // Withdrawal during WAIT, then confirm no write.
      withdraw(2, 1, 0, 32'h40, 32'h12345678, 4'hF, 0);
      access(2, 0, 1, 32'h40, 32'h0, 4'hF, 0);

      // Reset during WAIT of a store, then confirm no write.
      access(3, 0, 1, 32'h10, 32'h0, 4'hF, 0);
      reset_mid_wait(3, 32'h44, 32'hCAFEF00D);
      access(3, 0, 1, 32'h44, 32'h0, 4'hF, 0);

      // Both strobes high: store wins, data_read untouched.
      access(1, 0, 1, 32'h10, 32'h0, 4'hF, 0);
      access(1, 1, 1, 32'h30, 32'h00000055, 4'b0001, 0);
      access(1, 0, 1, 32'h30, 32'h0, 4'b0001, 0);

      // Randomized traffic.
      for (int u = 0; u < NU; u++) begin
         for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [3:0]  m;
            int          r;
            bit          wr;
            bit          rd;
            r = $urandom_range(0, 7);
            m = (r < 3) ? 4'b0001 : (r < 5) ? 4'b0011 : (r < 7) ? 4'b1111 : 4'($urandom);
            a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 3) != 0) begin
               if (m == 4'b0011) a[0] = 1'b0;
               else if (m == 4'b1111) a[1:0] = 2'b00;
            end
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'hFFFF_FFFC;
            else if (r == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 1023));
            d = $urandom;
            r = $urandom_range(0, 3);
            wr = (r == 0) || (r == 2);
            rd = (r != 0);
            if (u > 0 && $urandom_range(0, 9) == 0)
               withdraw(u, wr, rd, a, d, m, $urandom_range(0, u - 1));
            else
               access(u, wr, rd, a, d, m, $urandom_range(0, 1) == 1);
         end
         idle(u);
      end

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL leftover_expectations: %0d queued, required 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_data_memory.md
# riscv_data_memory

Word-organized data memory that acts as the responder on the core's data port. It accepts byte, halfword and word loads and stores using the data-port signals: valid strobes, byte address, byte-lane mask and ready/stall. It inserts a programmable number of wait states and aligns byte lanes in both directions. It flags misaligned or out-of-range accesses, and sits between the core and the data RAM.

## Interface
- `DEPTH_WORDS`, default 4096: number of 32-bit words; legal word index 0..DEPTH_WORDS-1.
- `WAIT_STATES`, default 1: cycles `data_ready` is held low per access; legal 0..15.
- Clocking: one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `data_read_valid`  in  1  load request.
- `data_write_valid`  in  1  store request.
- `data_addr`  in  32  byte address.
- `data_write`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `data_write_byte`  in  4  size mask, right-justified: 0001 byte, 0011 half, 1111 word; used for loads and stores.
- `data_read`  out  32  load data, right-justified and zero-filled above the access size (the initiator sign-extends).
- `data_ready`  out  1  high = responder can complete the presented request this cycle; low = initiator must stall and hold the request.
- `data_error`  out  1  one-cycle flag aligned with the response of a faulting access.

## Operation
- A request is presented when `data_read_valid | data_write_valid` is high. If both are high, the access is a store.
- A request completes on a rising edge where it is presented and `data_ready`=1.
- The request fields (address, data, mask, direction) must stay stable from first presentation until completion. The block does not latch them.
- Lane alignment (off = `data_addr[1:0]`):
  - Store lane enables = `data_write_byte << off`.
  - Store data = `data_write << 8*off`.
  - Load result = `mem[word] >> 8*off`, masked to the access size.
- Word index = `data_addr[31:2]`.
- An access is an error if any of the following holds:
  - the word index is ≥ DEPTH_WORDS;
  - the mask is not 0001, 0011 or 1111;
  - a half access has off[0]=1;
  - a word access has off≠0.
- On error: the store is suppressed, the load returns 0, and `data_error`=1 in the cycle after completion.
- FSM for WAIT_STATES ≥ 1, states IDLE, WAIT, GRANT, plus counter `cnt` (4 bits):
  - IDLE: `data_ready` = !request (combinational). On a request, go to GRANT if WAIT_STATES=1, otherwise go to WAIT with cnt=WAIT_STATES-2.
  - WAIT: `data_ready`=0. If the request is withdrawn, go to IDLE with no access. Else if cnt=0, go to GRANT; else decrement cnt.
  - GRANT: `data_ready`=1. If the request is present, it completes (store written / load captured). Go to IDLE either way; a withdrawn request is dropped.
- WAIT_STATES=0: no FSM; `data_ready` is constant 1 outside reset, and every presented request completes in the same cycle.
- Back-to-back: each new request after GRANT restarts the full wait sequence in IDLE.
- `data_read` holds its value until the next completed load. Stores and errored stores leave it unchanged.
- Memory contents are not reset. An X-free simulation initializes memory to 0.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state=IDLE, cnt=0, `data_read`=0, `data_error`=0.
  - `data_ready`=1 while no request is present.
- Stall length: exactly WAIT_STATES cycles of `data_ready`=0 per access, starting in the cycle the request is first presented.
- Store latency: the memory is updated at the completing edge. A load of the same address completing one edge later returns the new data.
- Load latency: `data_read` is valid in the cycle after the completing edge (registered). `data_error` has the same alignment and lasts one cycle.
- Reset asserted mid-WAIT: the pending access is discarded with no write, and the FSM is in IDLE immediately.
- `data_addr` wrap: upper address bits are not ignored. Any index beyond DEPTH_WORDS is an error, including 0xFFFF_FFFC.

## Test plan
- WAIT_STATES=0 store word: mask 1111, addr 0x10, data 0xDEADBEEF. Then load word at 0x10: `data_read`=0xDEADBEEF one cycle after the load edge, and `data_ready` is never low.
- Byte lanes: store byte 0xAA at 0x13 over word 0x11223344 → word becomes 0xAA223344. Load byte at 0x13 → 0x000000AA. Load half at 0x12 → 0x0000AA22.
- WAIT_STATES=3 load: `data_ready` is low for exactly 3 cycles from presentation, high in GRANT, and `data_read` updates the following cycle. An immediate second request sees 3 more low cycles.
- Errors:
  - half store at 0x21 → memory unchanged, `data_error` pulses 1 cycle;
  - word load at DEPTH_WORDS*4 → `data_read`=0, `data_error`=1;
  - mask 0101 → error.
- Withdrawal and reset: with WAIT_STATES=2, drop the store request during WAIT → no write and `data_ready` returns high. Assert `reset_n`=0 mid-WAIT of a store → no write, and all outputs are at reset values asynchronously.
- Simultaneous valids: read and write both high with data 0x55 at 0x30 → store performed and `data_read` unchanged.
